// File: rtl/sbox_rand_pkg.sv
// Shared constants and FSM state type for the masked-SBox randomness generator.
// Field offsets locate each 2-bit SBox random input inside the 18-bit bundle.
package sbox_rand_pkg;

   localparam int RND_BITS = 18;

   localparam int Z0_OFS  = 16;
   localparam int Z1_OFS  = 14;
   localparam int Z2_OFS  = 12;
   localparam int AZ0_OFS = 10;
   localparam int AZ1_OFS = 8;
   localparam int AZ2_OFS = 6;
   localparam int BZ0_OFS = 4;
   localparam int BZ1_OFS = 2;
   localparam int BZ2_OFS = 0;

   localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } gen_state_e;

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with reload port; out_bit is the bit shifted out on the next step.
// Reusable by any mask-randomness consumer that needs one fresh bit per step.
module lfsr_galois
   import sbox_rand_pkg::*;
#(
   parameter int                LFSR_W = 32,
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   output logic [LFSR_W-1:0] state,
   output logic              out_bit
);

   logic [LFSR_W-1:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
      end else if (load) begin
         r_lfsr <= load_val;
      end else if (step) begin
         r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
      end
   end

   assign state   = r_lfsr;
   assign out_bit = r_lfsr[0];

endmodule

// File: rtl/sbox_rand_gen.sv
// Collects 18 LFSR bits into a bundle of nine 2-bit SBox random inputs and offers it
// on a valid/ready handshake; supports reseeding and flags an all-zero LFSR.
module sbox_rand_gen
   import sbox_rand_pkg::*;
#(
   parameter int                LFSR_W = 32,
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              rnd_ready,
   output logic              rnd_valid,
   output logic [1:0]        z0,
   output logic [1:0]        z1,
   output logic [1:0]        z2,
   output logic [1:0]        az0,
   output logic [1:0]        az1,
   output logic [1:0]        az2,
   output logic [1:0]        bz0,
   output logic [1:0]        bz1,
   output logic [1:0]        bz2,
   output logic              stuck_err
);

   if (LFSR_W < 19) begin : g_bad_width
      $error("sbox_rand_gen: LFSR_W must be at least 19");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("sbox_rand_gen: SEED must be nonzero");
   end

   localparam logic [4:0] CNT_FULL = 5'(RND_BITS);

   gen_state_e            r_state, w_state_nxt;
   logic [4:0]            r_cnt, w_cnt_nxt;
   logic [RND_BITS-1:0]   r_buf, w_buf_nxt;
   logic                  r_stuck;
   logic [LFSR_W-1:0]     w_lfsr;
   logic [LFSR_W-1:0]     w_load_val;
   logic                  w_out_bit;
   logic                  w_zero;
   logic                  w_step;

   assign w_zero     = (w_lfsr == '0);
   assign w_load_val = (seed_in == '0) ? SEED : seed_in;
   assign w_step     = (r_state == FILL) && en && !seed_load && !w_zero;

   lfsr_galois #(
      .LFSR_W (LFSR_W),
      .TAPS   (TAPS),
      .SEED   (SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (w_step),
      .load     (seed_load),
      .load_val (w_load_val),
      .state    (w_lfsr),
      .out_bit  (w_out_bit)
   );

   // Bundle transfers when rnd_valid && rnd_ready at a rising edge; a same-edge reseed cancels it.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_buf_nxt   = r_buf;
      if (seed_load) begin
         w_state_nxt = FILL;
         w_cnt_nxt   = '0;
         w_buf_nxt   = '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_step) begin
                  w_buf_nxt = {r_buf[RND_BITS-2:0], w_out_bit};
                  w_cnt_nxt = r_cnt + 5'd1;
                  if (r_cnt + 5'd1 == CNT_FULL) begin
                     w_state_nxt = FULL;
                  end
               end
            end
            FULL: begin
               if (rnd_ready) begin
                  w_state_nxt = FILL;
                  w_cnt_nxt   = '0;
               end
            end
            default: w_state_nxt = FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FILL;
         r_cnt   <= '0;
         r_buf   <= '0;
         r_stuck <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_buf   <= w_buf_nxt;
         if (w_zero) begin
            r_stuck <= 1'b1;
         end
      end
   end

   assign rnd_valid = (r_state == FULL);
   assign stuck_err = r_stuck;

   assign z0  = r_buf[Z0_OFS  +: 2];
   assign z1  = r_buf[Z1_OFS  +: 2];
   assign z2  = r_buf[Z2_OFS  +: 2];
   assign az0 = r_buf[AZ0_OFS +: 2];
   assign az1 = r_buf[AZ1_OFS +: 2];
   assign az2 = r_buf[AZ2_OFS +: 2];
   assign bz0 = r_buf[BZ0_OFS +: 2];
   assign bz1 = r_buf[BZ1_OFS +: 2];
   assign bz2 = r_buf[BZ2_OFS +: 2];

endmodule
